edge_rate_meter: RTL and testbench



---
 rtl/edge_rate_meter.sv | 152 +++++++++++++++
 tb/tb_edge_rate_meter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_rate_meter.sv
// edge_rate_meter
//   Measures an asynchronous signal against clk. After a start request the
//   block waits (ARM) for the first rising edge of sig_in. It then counts
//   rising edges for a window of GATE_CYCLES clocks (GATE) and keeps the
//   clk-cycle distance between the last two edges. If no edge arrives within
//   GATE_CYCLES clocks of arming, the measurement ends with timeout set.
//
// Parameters
//   CNT_W        width of edge_cnt / last_period (4..32)
//   GATE_CYCLES  window length and ARM timeout, in clk cycles (2..2^24)
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   sig_in       asynchronous signal under measurement
//   start        one-cycle request; honoured only in IDLE
//   busy         high in ARM and GATE
//   done         one-cycle pulse when results are valid
//   edge_cnt     rising edges counted in the window (saturating)
//   last_period  clk cycles between the last two edges (saturating)
//   timeout      no edge seen while armed
//   ovf          edge_cnt or last_period saturated; sticky until next start
module edge_rate_meter #(
    parameter int CNT_W       = 32,
    parameter int GATE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] last_period,
    output logic             timeout,
    output logic             ovf
);

    localparam int               GW        = $clog2(GATE_CYCLES + 1);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]    GATE_ONE  = GW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

    state_t           state, stateNext;
    logic             sync1, sync2, hist;
    logic             risePulse;
    logic             gateLast;
    logic [GW-1:0]    gateCnt;
    logic [CNT_W-1:0] perCnt;

    // Two synchronizer flops plus a history flop; a rise sampled into sync1
    // at edge k shows up as risePulse during the cycle that ends at edge k+2.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign risePulse = sync2 & ~hist;
    assign gateLast  = (gateCnt == GATE_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) stateNext = ARM;
            ARM: begin
                busy = 1'b1;
                // An edge on the last armed cycle still opens the window.
                if (risePulse)     stateNext = GATE;
                else if (gateLast) stateNext = DONE;
            end
            GATE: begin
                busy = 1'b1;
                if (gateLast) stateNext = DONE;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gateCnt     <= '0;
            perCnt      <= '0;
            edge_cnt    <= '0;
            last_period <= '0;
            timeout     <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        gateCnt     <= '0;
                        edge_cnt    <= '0;
                        last_period <= '0;
                        timeout     <= 1'b0;
                        ovf         <= 1'b0;
                    end
                end
                ARM: begin
                    // The arming edge only opens the window and is not counted.
                    if (risePulse) begin
                        gateCnt <= '0;
                        perCnt  <= '0;
                    end else if (gateLast) begin
                        timeout <= 1'b1;
                    end else begin
                        gateCnt <= gateCnt + GATE_ONE;
                    end
                end
                GATE: begin
                    gateCnt <= gateCnt + GATE_ONE;
                    if (risePulse) begin
                        if (edge_cnt == CNT_MAX) ovf <= 1'b1;
                        else                     edge_cnt <= edge_cnt + CNT_ONE;
                        // The edge cycle itself closes the period, hence +1.
                        if (perCnt == CNT_MAX) begin
                            last_period <= CNT_MAX;
                            ovf         <= 1'b1;
                        end else begin
                            last_period <= perCnt + CNT_ONE;
                        end
                        perCnt <= '0;
                    end else if (perCnt != CNT_MAX) begin
                        perCnt <= perCnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_rate_meter.sv
module tb_edge_rate_meter;

    localparam int GC_A = 1000;
    localparam int GC_B = 100;

    logic        clk = 1'b0;
    logic        reset, sig_in, startA, startB;
    logic        busyA, doneA, timeoutA, ovfA;
    logic [31:0] edgeA, perA;
    logic        busyB, doneB, timeoutB, ovfB;
    logic [3:0]  edgeB, perB;

    int checks = 0;
    int errors = 0;
    int per    = 0;   // generator period; 0 = sig_in driven by hand
    int ph     = 0;

    edge_rate_meter #(.CNT_W(32), .GATE_CYCLES(GC_A)) dutA (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(startA),
        .busy(busyA), .done(doneA), .edge_cnt(edgeA), .last_period(perA),
        .timeout(timeoutA), .ovf(ovfA)
    );

    edge_rate_meter #(.CNT_W(4), .GATE_CYCLES(GC_B)) dutB (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(startB),
        .busy(busyB), .done(doneB), .edge_cnt(edgeB), .last_period(perB),
        .timeout(timeoutB), .ovf(ovfB)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int period;
        int expEdge;
        int expPer;
        int expOvf;
        int expTo;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (per > 0) begin
            ph     = (ph + 1) % per;
            sig_in = (ph < per / 2);
        end
    endtask

    // Tick until done (returns tick count) or -1 after limit ticks.
    task automatic waitDone(input bit useB, input int limit, output int n, output int busyBad);
        n = -1;
        busyBad = 0;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (useB ? doneB : doneA) begin
                n = i;
                break;
            end
            if (!(useB ? busyB : busyA)) busyBad++;
        end
    endtask

    vec_t vecs[10];

    initial begin
        int n, bb, cnt;

        vecs[0] = '{4,  15, 4,  1, 0};
        vecs[1] = '{6,  15, 6,  1, 0};
        vecs[2] = '{7,  14, 7,  0, 0};
        vecs[3] = '{10, 10, 10, 0, 0};
        vecs[4] = '{12, 8,  12, 0, 0};
        vecs[5] = '{15, 6,  15, 0, 0};
        vecs[6] = '{16, 6,  15, 1, 0};
        vecs[7] = '{20, 5,  15, 1, 0};
        vecs[8] = '{50, 2,  15, 1, 0};
        vecs[9] = '{0,  0,  0,  0, 1};

        reset = 1'b1; sig_in = 1'b0; startA = 1'b0; startB = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busyA, 0);
        chk("rst_done", doneA, 0);
        chk("rst_outs", {edgeA, perA} , 0);
        chk("rst_flags", {timeoutA, ovfA}, 0);
        reset = 1'b0;
        tick();

        // Nominal, start held high through the whole run and the DONE cycle.
        per = 10; ph = 0;
        startA = 1'b1;
        tick();
        chk("nom_busy_on_start", busyA, 1);
        waitDone(0, GC_A + 50, n, bb);
        chk("nom_done_seen", n > 0, 1);
        chk("nom_busy_held", bb, 0);
        chk("nom_edge_cnt", edgeA, 100);
        chk("nom_last_period", perA, 10);
        chk("nom_timeout", timeoutA, 0);
        chk("nom_ovf", ovfA, 0);
        tick();   // start on DONE cycle ignored -> IDLE
        chk("nom_done_one_cycle", doneA, 0);
        chk("nom_idle_after_done", busyA, 0);
        chk("nom_results_held", edgeA, 100);
        tick();   // start in IDLE right after DONE accepted
        chk("restart_accepted", busyA, 1);
        chk("restart_clears", edgeA, 0);
        startA = 1'b0;

        // Abort mid-GATE; reset also beats a simultaneous start.
        repeat (300) tick();
        chk("abort_busy_pre", busyA, 1);
        reset = 1'b1; startA = 1'b1;
        tick();
        reset = 1'b0; startA = 1'b0;
        chk("abort_busy", busyA, 0);
        chk("abort_done", doneA, 0);
        chk("abort_outs", {edgeA, perA}, 0);
        chk("abort_flags", {timeoutA, ovfA}, 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (doneA || busyA) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        startA = 1'b1;
        tick();
        startA = 1'b0;
        waitDone(0, GC_A + 50, n, bb);
        chk("fresh_done_seen", n > 0, 1);
        chk("fresh_edge_cnt", edgeA, 100);
        chk("fresh_last_period", perA, 10);
        chk("fresh_flags", {timeoutA, ovfA}, 0);

        // Timeout: done appears GC+1 cycles after the start cycle.
        per = 0; sig_in = 1'b0;
        repeat (4) tick();
        startA = 1'b1;
        tick();
        startA = 1'b0;
        waitDone(0, GC_A + 20, n, bb);
        chk("to_latency", n + 1, GC_A + 1);
        chk("to_timeout", timeoutA, 1);
        chk("to_edge_cnt", edgeA, 0);
        chk("to_last_period", perA, 0);
        chk("to_ovf", ovfA, 0);

        // Latency: rise sampled at S+5 enters GATE at S+7 (done at S+7+GC);
        // a second rise lands exactly in the final GATE cycle.
        repeat (4) tick();
        startA = 1'b1;
        tick();              // edge S
        startA = 1'b0;
        repeat (4) tick();   // edge S+4
        sig_in = 1'b1;
        repeat (10) tick();  // edge S+14
        sig_in = 1'b0;
        cnt = 0;
        for (int i = 15; i <= GC_A + 4; i++) begin
            tick();
            if (doneA) cnt++;
        end
        chk("lat_no_early_done", cnt, 0);
        sig_in = 1'b1;       // sampled at S+5+GC -> final GATE cycle
        waitDone(0, 20, n, bb);
        chk("lat_done_cycle", n, 3);
        chk("lat_final_edge_counted", edgeA, 1);
        chk("lat_last_period", perA, GC_A);
        chk("lat_flags", {timeoutA, ovfA}, 0);
        sig_in = 1'b0;

        // Saturation table on the CNT_W=4, GATE_CYCLES=100 instance.
        for (int v = 0; v < 10; v++) begin
            per = vecs[v].period; ph = 0;
            if (per == 0) sig_in = 1'b0;
            repeat (4) tick();
            startB = 1'b1;
            tick();
            startB = 1'b0;
            waitDone(1, 2 * GC_B + 80, n, bb);
            chk($sformatf("b%0d_done_seen", v), n > 0, 1);
            chk($sformatf("b%0d_edge_cnt", v), edgeB, vecs[v].expEdge);
            chk($sformatf("b%0d_last_period", v), perB, vecs[v].expPer);
            chk($sformatf("b%0d_ovf", v), ovfB, vecs[v].expOvf);
            chk($sformatf("b%0d_timeout", v), timeoutB, vecs[v].expTo);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
